// File: rtl/smac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : smac_pkg                                                        |
// | Purpose  : Shared types and constants for the SMAC output collector.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package smac_pkg;

    localparam int BW_DEF   = 128;
    localparam int NGRP_DEF = 4;
    localparam int SEL_W    = 2;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } collector_state_t;

endpackage
`default_nettype wire

// File: rtl/dp_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dp_out_fifo                                                     |
// | Purpose  : DEPTH-entry synchronous FIFO holding {last, data} beats.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dp_out_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == c_depth);
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd_ptr];

    // Storage carries no reset; the read side is qualified by empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dp_out_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dp_out_collector                                                |
// | Purpose  : Walks the data path output mux over NGRP groups and streams     |
// |            each group out through a small FIFO.                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dp_out_collector
    import smac_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int NGRP  = NGRP_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_start,
    input  logic [BW-1:0]    dp_out_data,
    output logic [SEL_W-1:0] sel_mux_out,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW-1:0]    out_data,
    output logic             out_last,
    output logic             drop_err
);

    localparam logic [SEL_W-1:0] c_last_grp = SEL_W'(NGRP - 1);

    collector_state_t r_state;
    collector_state_t w_state_nxt;
    logic [SEL_W-1:0] r_grp;
    logic [SEL_W-1:0] w_grp_nxt;
    logic             r_drop_err;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [BW:0]      w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grp      <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grp   <= w_grp_nxt;
            if (wb_start && (r_state == ST_COLLECT)) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Push decision uses current occupancy only, so a same-cycle pop never
    // frees a slot early.
    always_comb begin
        w_state_nxt = r_state;
        w_grp_nxt   = r_grp;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wb_start) begin
                    w_state_nxt = ST_COLLECT;
                    w_grp_nxt   = '0;
                end
            end
            ST_COLLECT: begin
                if (!w_fifo_full) begin
                    w_push = 1'b1;
                    if (r_grp == c_last_grp) begin
                        w_state_nxt = ST_IDLE;
                        w_grp_nxt   = '0;
                    end else begin
                        w_grp_nxt = r_grp + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grp_nxt   = '0;
            end
        endcase
    end

    dp_out_fifo #(
        .WIDTH (BW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({(r_grp == c_last_grp), dp_out_data}),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign sel_mux_out = (r_state == ST_COLLECT) ? r_grp : '0;
    assign busy        = (r_state == ST_COLLECT);
    assign drop_err    = r_drop_err;
    assign out_valid   = !w_fifo_empty;
    assign out_data    = out_valid ? w_head[BW-1:0] : '0;
    assign out_last    = out_valid & w_head[BW];
    assign w_pop       = out_valid & out_ready;

endmodule
`default_nettype wire

// File: tb/tb_dp_out_collector.sv
`default_nettype none
// Bench for dp_out_collector: directed cycle table followed by a randomized
// stream compared against a frame-level expected-beat queue.
module tb_dp_out_collector;

    localparam int BW = 128;
    localparam int CW = BW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_start;
    logic [BW-1:0] dp_out_data;
    logic [1:0]    sel_mux_out;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          drop_err;
    logic [31:0]   tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic       rdy;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       b;
        logic [1:0] s;
        logic       dr;
    } vec_t;

    vec_t        vecs[$];
    logic [BW:0] exp_q[$];
    logic        exp_drop;
    logic        acc_prev;
    logic        prev_valid;
    logic        prev_ready;
    logic [BW:0] prev_beat;

    always #5 clk = ~clk;

    always_comb dp_out_data = {tag, 96'h0} | (128'hA0 + 128'(sel_mux_out));

    dp_out_collector #(
        .BW    (BW),
        .NGRP  (4),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_start    (wb_start),
        .dp_out_data (dp_out_data),
        .sel_mux_out (sel_mux_out),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .drop_err    (drop_err)
    );

    task automatic chk(input string name, input int idx, input logic [CW-1:0] act,
                       input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic st, input logic rd, input logic v,
                       input logic [7:0] d, input logic l, input logic b,
                       input logic [1:0] s, input logic dr);
        vecs.push_back('{r, st, rd, v, d, l, b, s, dr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the randomized stream: check what is visible now, then
    // choose this cycle's inputs and update the expected-beat queue.
    task automatic stream_cycle(input int cyc, input logic allow_start, input int thr);
        logic [BW-1:0] dd;
        chk("drop_err", cyc, CW'(drop_err), CW'(exp_drop));
        if (acc_prev) chk("busy_after_start", cyc, CW'(busy), CW'(1));
        if (prev_valid && !prev_ready) begin
            chk("hold_valid", cyc, CW'(out_valid), CW'(1));
            chk("hold_beat", cyc, {out_last, out_data}, prev_beat);
        end
        if (!out_valid) begin
            chk("idle_zero", cyc, {out_last, out_data}, '0);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat @%0d: got %h expected none", cyc, {out_last, out_data});
        end else begin
            chk("beat", cyc, {out_last, out_data}, exp_q[0]);
        end

        out_ready = ($urandom_range(0, 99) < thr);
        wb_start  = allow_start && ($urandom_range(0, 5) == 0);
        acc_prev  = 1'b0;
        if (wb_start) begin
            if (busy) begin
                exp_drop = 1'b1;
            end else begin
                acc_prev = 1'b1;
                tag      = $urandom;
                for (int g = 0; g < 4; g++) begin
                    dd = {tag, 96'h0} | (128'hA0 + 128'(g));
                    exp_q.push_back({(g == 3), dd});
                end
            end
        end
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_beat  = {out_last, out_data};
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        wb_start  = 1'b0;
        out_ready = 1'b0;
        tag       = '0;

        // Basic frame, ready held high
        add(0,1,1, 0,8'h00,0,0,0,0); add(0,0,1, 0,8'h00,0,1,0,0);
        add(0,0,1, 1,8'hA0,0,1,1,0); add(0,0,1, 1,8'hA1,0,1,2,0);
        add(0,0,1, 1,8'hA2,0,1,3,0); add(0,0,1, 1,8'hA3,1,0,0,0);
        add(0,0,1, 0,8'h00,0,0,0,0);
        // Backpressure: whole frame buffered, then drained
        add(0,1,0, 0,8'h00,0,0,0,0); add(0,0,0, 0,8'h00,0,1,0,0);
        add(0,0,0, 1,8'hA0,0,1,1,0); add(0,0,0, 1,8'hA0,0,1,2,0);
        add(0,0,0, 1,8'hA0,0,1,3,0); add(0,0,0, 1,8'hA0,0,0,0,0);
        add(0,0,1, 1,8'hA0,0,0,0,0); add(0,0,1, 1,8'hA1,0,0,0,0);
        add(0,0,1, 1,8'hA2,0,0,0,0); add(0,0,1, 1,8'hA3,1,0,0,0);
        add(0,0,0, 0,8'h00,0,0,0,0);
        // Full stall: second frame starts against a full FIFO
        add(0,1,0, 0,8'h00,0,0,0,0); add(0,0,0, 0,8'h00,0,1,0,0);
        add(0,0,0, 1,8'hA0,0,1,1,0); add(0,0,0, 1,8'hA0,0,1,2,0);
        add(0,0,0, 1,8'hA0,0,1,3,0); add(0,0,0, 1,8'hA0,0,0,0,0);
        add(0,1,0, 1,8'hA0,0,0,0,0); add(0,0,0, 1,8'hA0,0,1,0,0);
        add(0,0,0, 1,8'hA0,0,1,0,0); add(0,0,1, 1,8'hA0,0,1,0,0);
        add(0,0,0, 1,8'hA1,0,1,0,0); add(0,0,0, 1,8'hA1,0,1,1,0);
        add(0,0,0, 1,8'hA1,0,1,1,0); add(0,0,1, 1,8'hA1,0,1,1,0);
        add(0,0,1, 1,8'hA2,0,1,1,0); add(0,0,1, 1,8'hA3,1,1,2,0);
        add(0,0,1, 1,8'hA0,0,1,3,0); add(0,0,1, 1,8'hA1,0,0,0,0);
        add(0,0,1, 1,8'hA2,0,0,0,0); add(0,0,1, 1,8'hA3,1,0,0,0);
        add(0,0,1, 0,8'h00,0,0,0,0);
        // Dropped start during collection
        add(0,1,1, 0,8'h00,0,0,0,0); add(0,0,1, 0,8'h00,0,1,0,0);
        add(0,1,1, 1,8'hA0,0,1,1,0); add(0,0,1, 1,8'hA1,0,1,2,1);
        add(0,0,1, 1,8'hA2,0,1,3,1); add(0,0,1, 1,8'hA3,1,0,0,1);
        add(0,0,1, 0,8'h00,0,0,0,1); add(0,0,1, 0,8'h00,0,0,0,1);
        // Reset mid-frame, then a clean frame
        add(0,1,0, 0,8'h00,0,0,0,1); add(0,0,0, 0,8'h00,0,1,0,1);
        add(0,0,0, 1,8'hA0,0,1,1,1); add(1,0,0, 1,8'hA0,0,1,2,1);
        add(0,0,0, 0,8'h00,0,0,0,0); add(0,1,1, 0,8'h00,0,0,0,0);
        add(0,0,1, 0,8'h00,0,1,0,0); add(0,0,1, 1,8'hA0,0,1,1,0);
        add(0,0,1, 1,8'hA1,0,1,2,0); add(0,0,1, 1,8'hA2,0,1,3,0);
        add(0,0,1, 1,8'hA3,1,0,0,0); add(0,0,1, 0,8'h00,0,0,0,0);

        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            wb_start  = vecs[i].start;
            out_ready = vecs[i].rdy;
            chk("valid",    i, CW'(out_valid),   CW'(vecs[i].v));
            chk("data",     i, CW'(out_data),    CW'(vecs[i].d));
            chk("last",     i, CW'(out_last),    CW'(vecs[i].l));
            chk("busy",     i, CW'(busy),        CW'(vecs[i].b));
            chk("sel",      i, CW'(sel_mux_out), CW'(vecs[i].s));
            chk("drop_tbl", i, CW'(drop_err),    CW'(vecs[i].dr));
            tick();
        end

        rst        = 1'b0;
        exp_drop   = 1'b0;
        acc_prev   = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_beat  = '0;
        for (int c = 0; c < 1500; c++) begin
            stream_cycle(c, 1'b1, ((c / 100) % 2 == 1) ? 25 : 90);
        end
        for (int k = 0; k < 300 && (exp_q.size() != 0 || out_valid); k++) begin
            stream_cycle(1500 + k, 1'b0, 100);
        end
        chk("drain_queue", 0, CW'(exp_q.size()), '0);
        chk("drain_valid", 0, CW'(out_valid), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
